// File: rtl/aes_result_streamer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_result_streamer: queues finished AES-128 blocks and streams them out as
// four 32-bit words over valid/ready. Revision: 1.0
// ---------------------------------------------------------------------------
module aes_result_streamer #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     done_enc,
  input  logic                     done_dec,
  input  logic [0:127]             result_in,
  input  logic                     m_ready,
  input  logic                     clr_err,
  output logic                     m_valid,
  output logic [0:31]              m_data,
  output logic                     m_last,
  output logic                     m_is_dec,
  output logic [CNT_W-1:0]         m_word,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     proto_err
);

  localparam int                 c_ptr_w     = $clog2(DEPTH);
  localparam logic [c_ptr_w:0]   c_cnt_one   = (c_ptr_w+1)'(1);
  localparam logic [c_ptr_w:0]   c_full      = (c_ptr_w+1)'(DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_one   = c_ptr_w'(1);
  localparam logic [CNT_W-1:0]   c_word_one  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   c_last_word = CNT_W'(3);

  typedef enum logic [0:0] {ST_EMPTY, ST_SEND} state_e;

  state_e               state_q, state_d;
  logic [0:127]         mem_q  [DEPTH];
  logic                 mode_q [DEPTH];
  logic [c_ptr_w-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [c_ptr_w:0]     count_q, count_d;
  logic [CNT_W-1:0]     word_q, word_d;
  logic                 overflow_q, overflow_d, proto_err_q, proto_err_d;

  logic                 cap_req, full, xfer, pop, wr_ok;
  logic [0:127]         head;
  logic [6:0]           w_off;

  assign cap_req = done_enc ^ done_dec;
  assign full    = (count_q == c_full);
  assign xfer    = (state_q == ST_SEND) && m_ready;
  assign pop     = xfer && (word_q == c_last_word);
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign wr_ok   = cap_req && (!full || pop);
  assign head    = mem_q[rd_ptr_q];
  assign w_off   = 7'(word_q) << 5;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    word_d      = word_q;
    overflow_d  = clr_err ? 1'b0 : overflow_q;
    proto_err_d = clr_err ? 1'b0 : proto_err_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + c_ptr_one;
    if (pop)   rd_ptr_d = rd_ptr_q + c_ptr_one;
    if (xfer)  word_d   = (word_q == c_last_word) ? '0 : word_q + c_word_one;
    if (wr_ok && !pop)      count_d = count_q + c_cnt_one;
    else if (!wr_ok && pop) count_d = count_q - c_cnt_one;
    if (cap_req && full && !pop) overflow_d  = 1'b1;
    if (done_enc && done_dec)    proto_err_d = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    m_valid  = 1'b0;
    m_data   = '0;
    m_last   = 1'b0;
    m_is_dec = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (count_d != '0) state_d = ST_SEND;
      end
      ST_SEND: begin
        m_valid  = 1'b1;
        m_data   = head[w_off +: 32];
        m_last   = (word_q == c_last_word);
        m_is_dec = mode_q[rd_ptr_q];
        if (count_d == '0) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  assign m_word    = word_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign proto_err = proto_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      word_q      <= '0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      word_q      <= word_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Storage needs no reset: outputs are gated by the FSM state.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q]  <= result_in;
      mode_q[wr_ptr_q] <= done_dec;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_result_streamer.sv
`default_nettype none
// Directed table-driven bench for aes_result_streamer.
module tb_aes_result_streamer;

  logic         clk = 1'b0;
  logic         reset;
  logic         done_enc, done_dec, m_ready, clr_err;
  logic [127:0] result_in;
  logic         m_valid, m_last, m_is_dec, overflow, proto_err;
  logic [31:0]  m_data;
  logic [1:0]   m_word;
  logic [1:0]   count;

  int checks   = 0;
  int failures = 0;

  aes_result_streamer #(.DEPTH(2), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .done_enc(done_enc), .done_dec(done_dec),
    .result_in(result_in), .m_ready(m_ready), .clr_err(clr_err),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_is_dec(m_is_dec),
    .m_word(m_word), .count(count), .overflow(overflow), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         de, dd;
    logic [127:0] din;
    logic         rdy, clr;
    logic         valid;
    logic [31:0]  data;
    logic         last, isdec;
    logic [1:0]   word, cnt;
    logic         ovf, perr;
  } vec_t;

  vec_t vecs [12];

  localparam logic [127:0] A1 = 128'h3925841D02DC09FBDC118597196A0B32;
  localparam logic [127:0] B2 = 128'h3243F6A8885A308D313198A2E0370734;
  localparam logic [127:0] VA = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] VB = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  localparam logic [127:0] VC = 128'hDEADBEEFCAFEF00D1234567887654321;
  localparam logic [127:0] VD = 128'h11111111222222223333333344444444;
  localparam logic [127:0] VE = 128'h55555555666666667777777788888888;
  localparam logic [127:0] VF = 128'h99999999AAAAAAAABBBBBBBBCCCCCCCC;
  localparam logic [127:0] VG = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] VH = 128'hA5A5A5A55A5A5A5AC3C3C3C33C3C3C3C;

  function automatic logic [31:0] wd(input logic [127:0] v, input int k);
    return v[127-32*k -: 32];
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Checks the word currently presented, then lets one edge pass.
  task automatic expect_word(input string tag, input logic [127:0] blk, input int k,
                             input logic isdec);
    chk({tag, "_valid"}, 128'(m_valid), 128'(1'b1));
    chk({tag, "_data"},  128'(m_data),  128'(wd(blk, k)));
    chk({tag, "_last"},  128'(m_last),  128'(k == 3));
    chk({tag, "_word"},  128'(m_word),  128'(k));
    chk({tag, "_isdec"}, 128'(m_is_dec), 128'(isdec));
    @(negedge clk);
  endtask

  task automatic pulse(input logic de, input logic dd, input logic [127:0] v);
    done_enc = de; done_dec = dd; result_in = v;
    @(negedge clk);
    done_enc = 1'b0; done_dec = 1'b0; result_in = '0;
  endtask

  initial begin
    reset = 1'b1; done_enc = 1'b0; done_dec = 1'b0; result_in = '0;
    m_ready = 1'b0; clr_err = 1'b0;

    vecs[0]  = '{1'b1,1'b0,A1,1'b1,1'b0, 1'b1,32'h3925841D,1'b0,1'b0,2'd0,2'd1,1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b0,'0,1'b1,1'b0, 1'b1,32'h02DC09FB,1'b0,1'b0,2'd1,2'd1,1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b0,'0,1'b1,1'b0, 1'b1,32'hDC118597,1'b0,1'b0,2'd2,2'd1,1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b0,'0,1'b1,1'b0, 1'b1,32'h196A0B32,1'b1,1'b0,2'd3,2'd1,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b0,'0,1'b1,1'b0, 1'b0,32'h0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b1,B2,1'b0,1'b0, 1'b1,32'h3243F6A8,1'b0,1'b1,2'd0,2'd1,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b0,'0,1'b1,1'b0, 1'b1,32'h885A308D,1'b0,1'b1,2'd1,2'd1,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b0,'0,1'b0,1'b0, 1'b1,32'h885A308D,1'b0,1'b1,2'd1,2'd1,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b0,'0,1'b0,1'b0, 1'b1,32'h885A308D,1'b0,1'b1,2'd1,2'd1,1'b0,1'b0};
    vecs[9]  = '{1'b0,1'b0,'0,1'b1,1'b0, 1'b1,32'h313198A2,1'b0,1'b1,2'd2,2'd1,1'b0,1'b0};
    vecs[10] = '{1'b0,1'b0,'0,1'b1,1'b0, 1'b1,32'hE0370734,1'b1,1'b1,2'd3,2'd1,1'b0,1'b0};
    vecs[11] = '{1'b0,1'b0,'0,1'b1,1'b0, 1'b0,32'h0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b0};

    repeat (2) @(negedge clk);
    chk("rst_valid", 128'(m_valid), 128'(1'b0));
    chk("rst_data",  128'(m_data),  128'(0));
    chk("rst_count", 128'(count),   128'(0));
    chk("rst_word",  128'(m_word),  128'(0));
    chk("rst_ovf",   128'(overflow), 128'(1'b0));
    chk("rst_perr",  128'(proto_err), 128'(1'b0));
    reset = 1'b0;
    @(negedge clk);

    // Single encrypt and decrypt-with-stall.
    for (int i = 0; i < 12; i++) begin
      done_enc = vecs[i].de; done_dec = vecs[i].dd; result_in = vecs[i].din;
      m_ready = vecs[i].rdy; clr_err = vecs[i].clr;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 128'(m_valid),   128'(vecs[i].valid));
      chk($sformatf("vec%0d_data", i),  128'(m_data),    128'(vecs[i].data));
      chk($sformatf("vec%0d_last", i),  128'(m_last),    128'(vecs[i].last));
      chk($sformatf("vec%0d_isdec", i), 128'(m_is_dec),  128'(vecs[i].isdec));
      chk($sformatf("vec%0d_word", i),  128'(m_word),    128'(vecs[i].word));
      chk($sformatf("vec%0d_count", i), 128'(count),     128'(vecs[i].cnt));
      chk($sformatf("vec%0d_ovf", i),   128'(overflow),  128'(vecs[i].ovf));
      chk($sformatf("vec%0d_perr", i),  128'(proto_err), 128'(vecs[i].perr));
    end
    done_enc = 1'b0; done_dec = 1'b0; result_in = '0; m_ready = 1'b0;

    // Overflow under backpressure: C is dropped.
    pulse(1'b1, 1'b0, VA);
    pulse(1'b1, 1'b0, VB);
    pulse(1'b1, 1'b0, VC);
    chk("ovf_count", 128'(count), 128'(2));
    chk("ovf_flag",  128'(overflow), 128'(1'b1));
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) expect_word($sformatf("ovfA%0d", k), VA, k, 1'b0);
    for (int k = 0; k < 4; k++) expect_word($sformatf("ovfB%0d", k), VB, k, 1'b0);
    chk("ovf_drain_valid", 128'(m_valid), 128'(1'b0));
    chk("ovf_drain_count", 128'(count), 128'(0));
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    chk("ovf_clr", 128'(overflow), 128'(1'b0));

    // Full FIFO with a capture on the same edge as the last-word pop.
    m_ready = 1'b0;
    pulse(1'b1, 1'b0, VD);
    pulse(1'b1, 1'b0, VE);
    chk("full_count", 128'(count), 128'(2));
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) expect_word($sformatf("fullD%0d", k), VD, k, 1'b0);
    chk("fullD3_word", 128'(m_word), 128'(3));
    pulse(1'b1, 1'b0, VF);
    chk("full_pop_count", 128'(count), 128'(2));
    chk("full_pop_ovf",   128'(overflow), 128'(1'b0));
    for (int k = 0; k < 4; k++) expect_word($sformatf("fullE%0d", k), VE, k, 1'b0);
    for (int k = 0; k < 4; k++) expect_word($sformatf("fullF%0d", k), VF, k, 1'b0);
    chk("full_drain_valid", 128'(m_valid), 128'(1'b0));

    // Protocol error, clear, and clear losing to a fresh error.
    pulse(1'b1, 1'b1, VA);
    chk("perr_flag",  128'(proto_err), 128'(1'b1));
    chk("perr_count", 128'(count), 128'(0));
    chk("perr_valid", 128'(m_valid), 128'(1'b0));
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    chk("perr_clr", 128'(proto_err), 128'(1'b0));
    clr_err = 1'b1; pulse(1'b1, 1'b1, VB); clr_err = 1'b0;
    chk("perr_clr_vs_new", 128'(proto_err), 128'(1'b1));
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    chk("perr_clr2", 128'(proto_err), 128'(1'b0));

    // Asynchronous reset mid-block.
    m_ready = 1'b1;
    pulse(1'b1, 1'b0, VG);
    expect_word("rstG0", VG, 0, 1'b0);
    chk("rstG1_word", 128'(m_word), 128'(1));
    #2 reset = 1'b1;
    #1;
    chk("amid_valid", 128'(m_valid), 128'(1'b0));
    chk("amid_count", 128'(count), 128'(0));
    chk("amid_word",  128'(m_word), 128'(0));
    chk("amid_data",  128'(m_data), 128'(0));
    #1 reset = 1'b0;
    @(negedge clk);
    pulse(1'b0, 1'b1, VH);
    for (int k = 0; k < 4; k++) expect_word($sformatf("postH%0d", k), VH, k, 1'b1);
    chk("postH_valid", 128'(m_valid), 128'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
